// File: rtl/onchip_mem_tester_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_mem_tester_pkg
//  Purpose  : Shared types and helpers for the on-chip memory tester.
//             - FSM state encoding
//             - Galois LFSR tap constant (x^32+x^22+x^2+x+1)
//             - next_pattern(): one step of the test-pattern generator
//  Config   : ONCHIP_MEM_TESTER_LFSR_EN selects the LFSR pattern; otherwise
//             the pattern is a simple increment.
//  Revision : 1.0 - initial release
// ============================================================================
package onchip_mem_tester_pkg;

  // Generator datapath width. The top level zero-extends its DATA_W pattern
  // into this width and truncates the result, so increment wraps modulo
  // 2^DATA_W for any DATA_W up to PAT_W.
  localparam int PAT_W = 64;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [PAT_W-1:0] next_pattern(input logic [PAT_W-1:0] cur);
`ifdef ONCHIP_MEM_TESTER_LFSR_EN
    logic [31:0] s;
    // Right-shifting Galois form: the bit shifted out folds back via the taps.
    s = cur[31:0];
    s = {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    return {{(PAT_W-32){1'b0}}, s};
`else
    return cur + PAT_W'(1);
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/onchip_mem_tester_rdpipe.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_mem_tester_rdpipe
//  Purpose  : Valid-bit shift register that tracks outstanding reads with a
//             fixed slave read latency. A bit pushed on an accepted read
//             emerges on valid_o exactly DEPTH cycles later, i.e. in the
//             cycle where the matching readdata is on the bus.
//  Ports    : clk      - system clock
//             reset_n  - asynchronous active-low reset
//             push_i   - a read was accepted this cycle
//             valid_o  - readdata for an earlier read is valid this cycle
//             empty_o  - no read in flight (all stages clear)
//  Revision : 1.0 - initial release
// ============================================================================
module onchip_mem_tester_rdpipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push_i,
  output logic valid_o,
  output logic empty_o
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;

  // Concatenate then truncate so the same expression works for DEPTH==1.
  assign vld_d = DEPTH'({vld_q, push_i});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign valid_o = vld_q[DEPTH-1];
  assign empty_o = (vld_q == '0);

endmodule
`default_nettype wire

// File: rtl/onchip_mem_tester.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_mem_tester
//  Purpose  : Avalon-MM master BIST engine for a single-port on-chip RAM.
//             One pass writes a generated pattern over [base, base+count),
//             reads every word back with pipelined reads and counts the
//             words that differ from the regenerated pattern.
//  Config   : `define ONCHIP_MEM_TESTER_LFSR_EN to use a 32-bit Galois LFSR
//             pattern (requires DATA_W==32) instead of seed+i.
//  Ports    : clk, reset_n            - clock, async active-low reset
//             start                   - launch pulse (only honoured in IDLE)
//             base_addr/word_count/seed - pass parameters, latched on start
//             busy, done              - pass status
//             err_count, first_err_addr, first_err_data - pass results
//             avm_*                   - Avalon-MM master interface
//  Revision : 1.0 - initial release
// ============================================================================
module onchip_mem_tester
  import onchip_mem_tester_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [DATA_W-1:0]   first_err_data,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic                avm_read,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("onchip_mem_tester: READ_LATENCY must be in 1..4");
  end

  if (DATA_W > PAT_W || (DATA_W % 8) != 0) begin : g_bad_data_w
    $error("onchip_mem_tester: DATA_W must be a multiple of 8 and <= 64");
  end

`ifdef ONCHIP_MEM_TESTER_LFSR_EN
  if (DATA_W != 32) begin : g_lfsr_width
    $error("onchip_mem_tester: LFSR pattern requires DATA_W == 32");
  end
`endif

  localparam int             BE_W    = DATA_W / 8;
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] ERR_SAT = {1'b1, {ADDR_W{1'b0}}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e              state_q,     state_d;
  logic [ADDR_W-1:0]   base_q,      base_d;
  logic [ADDR_W:0]     cnt_q,       cnt_d;
  logic [ADDR_W:0]     idx_q,       idx_d;       // request index i
  logic [ADDR_W-1:0]   addr_q,      addr_d;      // base + i (mod 2^ADDR_W)
  logic [DATA_W-1:0]   wr_pat_q,    wr_pat_d;    // P(i), write generator
  logic [ADDR_W-1:0]   cmp_addr_q,  cmp_addr_d;  // base + j
  logic [DATA_W-1:0]   cmp_pat_q,   cmp_pat_d;   // P(j), compare generator
  logic [ADDR_W:0]     err_cnt_q,   err_cnt_d;
  logic [ADDR_W-1:0]   ferr_addr_q, ferr_addr_d;
  logic [DATA_W-1:0]   ferr_data_q, ferr_data_d;

  logic                w_wr_act;
  logic                w_rd_act;
  logic                w_last;
  logic                w_rd_push;
  logic                w_rd_vld;
  logic                w_pipe_empty;
  logic [DATA_W-1:0]   w_seed_eff;
  logic [DATA_W-1:0]   w_wr_pat_next;
  logic [DATA_W-1:0]   w_cmp_pat_next;

`ifdef ONCHIP_MEM_TESTER_LFSR_EN
  // An all-zero LFSR state would lock up, so a zero seed becomes 1.
  assign w_seed_eff = (seed == '0) ? DATA_W'(1) : seed;
`else
  assign w_seed_eff = seed;
`endif

  // Write and compare generators are separate copies stepped by i and j.
  assign w_wr_pat_next  = DATA_W'(next_pattern(PAT_W'(wr_pat_q)));
  assign w_cmp_pat_next = DATA_W'(next_pattern(PAT_W'(cmp_pat_q)));

  assign w_wr_act  = (state_q == ST_WRITE);
  assign w_rd_act  = (state_q == ST_READ);
  assign w_last    = ((idx_q + CNT_ONE) == cnt_q);
  assign w_rd_push = w_rd_act && !avm_waitrequest;

  onchip_mem_tester_rdpipe #(
    .DEPTH   (READ_LATENCY)
  ) u_rdpipe (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (w_rd_push),
    .valid_o (w_rd_vld),
    .empty_o (w_pipe_empty)
  );

  // --------------------------------------------------------------------------
  // Next-state / datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    wr_pat_d    = wr_pat_q;
    cmp_addr_d  = cmp_addr_q;
    cmp_pat_d   = cmp_pat_q;
    err_cnt_d   = err_cnt_q;
    ferr_addr_d = ferr_addr_q;
    ferr_data_d = ferr_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d      = base_addr;
          cnt_d       = word_count;
          idx_d       = '0;
          addr_d      = base_addr;
          wr_pat_d    = w_seed_eff;
          cmp_addr_d  = base_addr;
          cmp_pat_d   = w_seed_eff;
          err_cnt_d   = '0;
          ferr_addr_d = '0;
          ferr_data_d = '0;
          state_d     = (word_count == '0) ? ST_DONE : ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (!avm_waitrequest) begin
          if (w_last) begin
            state_d = ST_READ;
            idx_d   = '0;
            addr_d  = base_q;
          end else begin
            idx_d    = idx_q + CNT_ONE;
            addr_d   = addr_q + ADDR_W'(1);
            wr_pat_d = w_wr_pat_next;
          end
        end
      end

      ST_READ: begin
        if (!avm_waitrequest) begin
          if (w_last) begin
            state_d = ST_DRAIN;
          end else begin
            idx_d  = idx_q + CNT_ONE;
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (w_pipe_empty) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Compare path runs independently of the request side: it only follows
    // the valid pipeline, which is never active in IDLE.
    if (w_rd_vld) begin
      cmp_addr_d = cmp_addr_q + ADDR_W'(1);
      cmp_pat_d  = w_cmp_pat_next;
      if (avm_readdata != cmp_pat_q) begin
        if (err_cnt_q == '0) begin
          ferr_addr_d = cmp_addr_q;
          ferr_data_d = avm_readdata;
        end
        if (err_cnt_q != ERR_SAT) begin
          err_cnt_d = err_cnt_q + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      wr_pat_q    <= '0;
      cmp_addr_q  <= '0;
      cmp_pat_q   <= '0;
      err_cnt_q   <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      wr_pat_q    <= wr_pat_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_pat_q   <= cmp_pat_d;
      err_cnt_q   <= err_cnt_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_data_q <= ferr_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registered state so they are stable during stalls
  // --------------------------------------------------------------------------
  assign avm_chipselect = w_wr_act | w_rd_act;
  assign avm_write      = w_wr_act;
  assign avm_read       = w_rd_act;
  assign avm_byteenable = {BE_W{avm_chipselect}};
  assign avm_address    = avm_chipselect ? addr_q : '0;
  assign avm_writedata  = w_wr_act ? wr_pat_q : '0;

  // busy drops in the DONE cycle, so busy and done never overlap.
  assign busy           = w_wr_act | w_rd_act | (state_q == ST_DRAIN);
  assign done           = (state_q == ST_DONE);

  assign err_count      = err_cnt_q;
  assign first_err_addr = ferr_addr_q;
  assign first_err_data = ferr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_tester.sv
`default_nettype none
// ============================================================================
//  Module   : tb_onchip_mem_tester
//  Purpose  : Directed self-checking bench. Two DUTs run in lockstep on the
//             same commands: READ_LATENCY=1 (u_dut0) and READ_LATENCY=2
//             (u_dut1), each with its own RAM model. Bus-level checks are
//             made on u_dut0.
//  Config   : honours ONCHIP_MEM_TESTER_LFSR_EN for the expected pattern.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_tester;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int BUDGET = 20000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          clr = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic [DW-1:0] seed = '0;
  logic          waitreq;
  logic          flip = 1'b0;
  logic          stall_en = 1'b0;

  logic          busy0, done0, cs0, wr0, rd0;
  logic [AW:0]   err0;
  logic [AW-1:0] faddr0, addr0;
  logic [DW-1:0] fdata0, wd0, rdata0;
  logic [BW-1:0] be0;

  logic          busy1, done1, cs1, wr1, rd1;
  logic [AW:0]   err1;
  logic [AW-1:0] faddr1, addr1;
  logic [DW-1:0] fdata1, wd1, rdata1, rq1;
  logic [BW-1:0] be1;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  onchip_mem_tester #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .seed(seed), .busy(busy0), .done(done0),
    .err_count(err0), .first_err_addr(faddr0), .first_err_data(fdata0),
    .avm_address(addr0), .avm_byteenable(be0), .avm_chipselect(cs0),
    .avm_write(wr0), .avm_read(rd0), .avm_writedata(wd0),
    .avm_readdata(rdata0), .avm_waitrequest(waitreq)
  );

  onchip_mem_tester #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .seed(seed), .busy(busy1), .done(done1),
    .err_count(err1), .first_err_addr(faddr1), .first_err_data(fdata1),
    .avm_address(addr1), .avm_byteenable(be1), .avm_chipselect(cs1),
    .avm_write(wr1), .avm_read(rd1), .avm_writedata(wd1),
    .avm_readdata(rdata1), .avm_waitrequest(waitreq)
  );

  // ---------------------------------------------------------------- checker
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model of the test pattern P(i).
  function automatic logic [31:0] tb_pat(input logic [31:0] s, input int i);
    logic [31:0] v;
`ifdef ONCHIP_MEM_TESTER_LFSR_EN
    v = (s == 32'h0) ? 32'h1 : s;
    for (int k = 0; k < i; k++) v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
`else
    v = s + 32'(i);
`endif
    return v;
  endfunction

  // ------------------------------------------------------------ RAM models
  logic [DW-1:0] mem0 [0:(1<<AW)-1];
  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  int            nwr0;
  logic [DW-1:0] fwd0;
  logic          cs_seen;

  function automatic logic [DW-1:0] corrupt(input logic [AW-1:0] a);
    return (flip && a == 12'h013) ? 32'h1 : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (cs0 && !waitreq) begin
      if (wr0) mem0[addr0] <= wd0;
      if (rd0) rdata0 <= mem0[addr0] ^ corrupt(addr0);
    end
    if (clr) begin
      nwr0    <= 0;
      cs_seen <= 1'b0;
    end else begin
      if (cs0) cs_seen <= 1'b1;
      if (cs0 && wr0 && !waitreq) begin
        if (nwr0 == 0) fwd0 <= wd0;
        nwr0 <= nwr0 + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (cs1 && !waitreq) begin
      if (wr1) mem1[addr1] <= wd1;
      if (rd1) rq1 <= mem1[addr1] ^ corrupt(addr1);
    end
    rdata1 <= rq1;
  end

  // ------------------------------------------------ waitrequest generator
  // Stalls the 2nd write and the 4th read for three cycles each.
  int acc_wr, acc_rd, wcyc, nstall;
  assign waitreq = stall_en && (wcyc < 3) &&
                   ((wr0 && acc_wr == 1) || (rd0 && acc_rd == 3));

  always @(posedge clk) begin
    if (clr) begin
      acc_wr <= 0; acc_rd <= 0; wcyc <= 0; nstall <= 0;
    end else if (cs0) begin
      if (waitreq) begin
        wcyc   <= wcyc + 1;
        nstall <= nstall + 1;
      end else begin
        wcyc <= 0;
        if (wr0) acc_wr <= acc_wr + 1;
        if (rd0) acc_rd <= acc_rd + 1;
      end
    end
  end

  // Requests must hold still while stalled.
  logic                 hold_v = 1'b0;
  logic [AW+DW+1:0]     held;
  always @(negedge clk) begin
    if (hold_v) chk("stall_hold", {addr0, wd0, wr0, rd0}, held);
    hold_v = cs0 && waitreq;
    held   = {addr0, wd0, wr0, rd0};
  end

  // ------------------------------------------------------------ pass driver
  int t_done0, t_done1;

  task automatic run_pass(input string tag, input logic [AW-1:0] b, input logic [AW:0] n,
                          input logic [DW-1:0] s, input bit poke);
    int cyc;
    @(posedge clk); #1;
    base_addr = b; word_count = n; seed = s; start = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clr = 1'b0;
    chk({tag, ".busy"}, busy0, (n != 0));
    cyc = 1; t_done0 = -1; t_done1 = -1;
    forever begin
      if (done0 && t_done0 < 0) t_done0 = cyc;
      if (done1 && t_done1 < 0) t_done1 = cyc;
      if ((t_done0 >= 0 && t_done1 >= 0) || cyc >= BUDGET) break;
      // A second start while the pass is running must be ignored.
      if (poke && cyc == 3) begin
        base_addr = 12'h200; word_count = 13'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, ".timeout"}, (cyc < BUDGET), 1'b1);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, {done0, done1}, 2'b00);
  endtask

  task automatic chk_mem(input string tag, input logic [AW-1:0] b, input int n,
                         input logic [DW-1:0] s);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i);
      chk({tag, ".mem0"}, mem0[a], tb_pat(s, i));
      chk({tag, ".mem1"}, mem1[a], tb_pat(s, i));
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int ndone;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.status", {busy0, done0, err0, faddr0, fdata0}, '0);
    chk("rst.bus", {cs0, wr0, rd0, be0, addr0, wd0}, '0);
    reset_n = 1'b1;

    // Fill / verify
    run_pass("fill", 12'h010, 13'd8, 32'hA5A5_0000, 1'b0);
    chk("fill.lat0", t_done0, 19);
    chk("fill.lat1", t_done1, 20);
    chk("fill.err", {err0, err1}, '0);
    chk("fill.nwr", nwr0, 8);
    chk("fill.ram017", mem0[12'h017], tb_pat(32'hA5A5_0000, 7));
    chk_mem("fill", 12'h010, 8, 32'hA5A5_0000);

    // Corruption of one word on readback
    flip = 1'b1;
    run_pass("corr", 12'h010, 13'd8, 32'hA5A5_0000, 1'b0);
    flip = 1'b0;
    chk("corr.err0", err0, 1);
    chk("corr.err1", err1, 1);
    chk("corr.faddr", {faddr0, faddr1}, {12'h013, 12'h013});
    chk("corr.fdata0", fdata0, tb_pat(32'hA5A5_0000, 3) ^ 32'h1);
    chk("corr.fdata1", fdata1, tb_pat(32'hA5A5_0000, 3) ^ 32'h1);

    // Zero-length pass: immediate done, no bus activity, results cleared
    run_pass("zero", 12'h123, 13'd0, 32'h0, 1'b0);
    chk("zero.lat", t_done0, 1);
    chk("zero.no_cs", cs_seen, 1'b0);
    chk("zero.results", {err0, faddr0, fdata0}, '0);

    // Range crossing the top of the address space
    run_pass("wrap", 12'hFFE, 13'd4, 32'h1234_5678, 1'b0);
    chk("wrap.err", {err0, err1}, '0);
    chk("wrap.nwr", nwr0, 4);
    chk_mem("wrap", 12'hFFE, 4, 32'h1234_5678);
    chk("wrap.ram000", mem0[12'h000], tb_pat(32'h1234_5678, 2));

    // Slave stalls on the 2nd write and 4th read
    stall_en = 1'b1;
    run_pass("stall", 12'h040, 13'd8, 32'hDEAD_0000, 1'b0);
    stall_en = 1'b0;
    chk("stall.cycles", nstall, 6);
    chk("stall.lat0", t_done0, 25);
    chk("stall.err", {err0, err1}, '0);
    chk_mem("stall", 12'h040, 8, 32'hDEAD_0000);

    // Start pulsed during WRITE is ignored
    run_pass("poke", 12'h300, 13'd8, 32'h0BAD_F00D, 1'b1);
    chk("poke.lat0", t_done0, 19);
    chk("poke.nwr", nwr0, 8);
    chk("poke.err", {err0, err1}, '0);
    chk_mem("poke", 12'h300, 8, 32'h0BAD_F00D);

`ifdef ONCHIP_MEM_TESTER_LFSR_EN
    run_pass("lfsr", 12'h500, 13'd6, 32'h0, 1'b0);
    chk("lfsr.first_wd", fwd0, 32'h1);
    chk("lfsr.err", {err0, err1}, '0);
    chk_mem("lfsr", 12'h500, 6, 32'h0);
`endif

    // Reset mid-READ after an error has been recorded
    flip = 1'b1;
    @(posedge clk); #1;
    base_addr = 12'h010; word_count = 13'd8; seed = 32'hA5A5_0000; start = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clr = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("rstmid.in_read", rd0, 1'b1);
    chk("rstmid.err_before", err0, 1);
    reset_n = 1'b0;
    #1;
    chk("rstmid.status", {busy0, done0, err0, faddr0, fdata0}, '0);
    chk("rstmid.bus", {cs0, wr0, rd0, be0, addr0, wd0}, '0);
    chk("rstmid.dut1", {busy1, done1, cs1, err1}, '0);
    flip = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done0 || done1 || busy0) ndone++;
    end
    chk("rstmid.no_done", ndone, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Byteenable must track chipselect on every cycle.
  always @(negedge clk) begin
    if (reset_n) chk("byteenable", be0, {BW{cs0}});
  end

endmodule
`default_nettype wire
